// File: rtl/asyncfifo_gray.sv
`default_nettype none
// ============================================================================
// Module   : asyncfifo_gray
// Purpose  : Dual-clock FIFO. Binary/Gray pointer pairs per domain, only the
//            Gray copies cross through multi-flop synchronisers. Registered
//            full/empty, occupancy counts, almost thresholds, sticky
//            overflow/underflow, show-ahead or registered read data.
// Revision : 1.0 - initial release
// ============================================================================
module asyncfifo_gray #(
  parameter int WIDTH       = 32,
  parameter int AWIDTH      = 10,
  parameter bit SHOWAHEAD   = 1'b1,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_TH    = (1 << AWIDTH) - 4,
  parameter int AEMPTY_TH   = 4
) (
  input  logic              wrclk,
  input  logic              wr_aclr,
  input  logic              rdclk,
  input  logic              rd_aclr,
  input  logic [WIDTH-1:0]  data,
  input  logic              wrreq,
  output logic              full,
  output logic              almost_full,
  output logic [AWIDTH:0]   wrusedw,
  output logic              wr_overflow,
  input  logic              rdreq,
  output logic [WIDTH-1:0]  q,
  output logic              empty,
  output logic              almost_empty,
  output logic [AWIDTH:0]   rdusedw,
  output logic              rd_underflow
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] AF_TH = AFULL_TH[AWIDTH:0];
  localparam logic [AWIDTH:0] AE_TH = AEMPTY_TH[AWIDTH:0];

  function automatic logic [AWIDTH:0] gray2bin(input logic [AWIDTH:0] g);
    logic [AWIDTH:0] b;
    b[AWIDTH] = g[AWIDTH];
    for (int i = AWIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [AWIDTH:0] bin2gray(input logic [AWIDTH:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------- write side
  logic [AWIDTH:0] wbin_q,  wbin_d;
  logic [AWIDTH:0] wgray_q, wgray_d;
  logic [AWIDTH:0] rsync_q [SYNC_STAGES];
  logic [AWIDTH:0] rsync_d [SYNC_STAGES];
  logic [AWIDTH:0] wrusedw_q, wrusedw_d;
  logic            full_q, full_d;
  logic            almost_full_q, almost_full_d;
  logic            wr_overflow_q, wr_overflow_d;
  logic            wr_accept;
  logic [AWIDTH:0] rgray_at_w;

  // Next write pointer, synchroniser shift and flags. Flags are computed from
  // the values the registers will hold after this edge so they are exact with
  // respect to the (possibly stale) synchronised read pointer.
  always_comb begin
    wr_accept = wrreq & ~full_q;
    wbin_d    = wbin_q + {{AWIDTH{1'b0}}, wr_accept};
    wgray_d   = bin2gray(wbin_d);
    rsync_d[0] = rgray_q;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      rsync_d[i] = rsync_q[i-1];
    end
    rgray_at_w    = rsync_d[SYNC_STAGES-1];
    // Full when the write pointer is one lap ahead: Gray top two bits differ.
    full_d        = (wgray_d == {~rgray_at_w[AWIDTH:AWIDTH-1], rgray_at_w[AWIDTH-2:0]});
    wrusedw_d     = wbin_d - gray2bin(rgray_at_w);
    almost_full_d = (wrusedw_d >= AF_TH);
    wr_overflow_d = wr_overflow_q | (wrreq & full_q);
  end

  // Write-domain state registers.
  always_ff @(posedge wrclk or posedge wr_aclr) begin
    if (wr_aclr) begin
      wbin_q        <= '0;
      wgray_q       <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) rsync_q[i] <= '0;
      wrusedw_q     <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      wr_overflow_q <= 1'b0;
    end else begin
      wbin_q        <= wbin_d;
      wgray_q       <= wgray_d;
      for (int i = 0; i < SYNC_STAGES; i++) rsync_q[i] <= rsync_d[i];
      wrusedw_q     <= wrusedw_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      wr_overflow_q <= wr_overflow_d;
    end
  end

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge wrclk) begin
    if (wr_accept) mem[wbin_q[AWIDTH-1:0]] <= data;
  end

  // ----------------------------------------------------------------- read side
  logic [AWIDTH:0] rbin_q,  rbin_d;
  logic [AWIDTH:0] rgray_q, rgray_d;
  logic [AWIDTH:0] wsync_q [SYNC_STAGES];
  logic [AWIDTH:0] wsync_d [SYNC_STAGES];
  logic [AWIDTH:0] rdusedw_q, rdusedw_d;
  logic            empty_q, empty_d;
  logic            almost_empty_q, almost_empty_d;
  logic            rd_underflow_q, rd_underflow_d;
  logic            rd_accept;
  logic [AWIDTH:0] wgray_at_r;
  logic [WIDTH-1:0] head_word;

  // Next read pointer, synchroniser shift and flags, mirroring the write side.
  always_comb begin
    rd_accept = rdreq & ~empty_q;
    rbin_d    = rbin_q + {{AWIDTH{1'b0}}, rd_accept};
    rgray_d   = bin2gray(rbin_d);
    wsync_d[0] = wgray_q;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      wsync_d[i] = wsync_q[i-1];
    end
    wgray_at_r     = wsync_d[SYNC_STAGES-1];
    empty_d        = (rgray_d == wgray_at_r);
    rdusedw_d      = gray2bin(wgray_at_r) - rbin_d;
    almost_empty_d = (rdusedw_d <= AE_TH);
    rd_underflow_d = rd_underflow_q | (rdreq & empty_q);
  end

  // Read-domain state registers.
  always_ff @(posedge rdclk or posedge rd_aclr) begin
    if (rd_aclr) begin
      rbin_q         <= '0;
      rgray_q        <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) wsync_q[i] <= '0;
      rdusedw_q      <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      rd_underflow_q <= 1'b0;
    end else begin
      rbin_q         <= rbin_d;
      rgray_q        <= rgray_d;
      for (int i = 0; i < SYNC_STAGES; i++) wsync_q[i] <= wsync_d[i];
      rdusedw_q      <= rdusedw_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      rd_underflow_q <= rd_underflow_d;
    end
  end

  assign head_word = mem[rbin_q[AWIDTH-1:0]];

  generate
    if (SHOWAHEAD) begin : g_q_showahead
      assign q = head_word;
    end else begin : g_q_registered
      logic [WIDTH-1:0] q_q, q_d;

      // Output word loads only on an accepted read and holds otherwise.
      always_comb begin
        q_d = q_q;
        if (rd_accept) q_d = head_word;
      end

      // Registered read data.
      always_ff @(posedge rdclk or posedge rd_aclr) begin
        if (rd_aclr) q_q <= '0;
        else         q_q <= q_d;
      end

      assign q = q_q;
    end
  endgenerate

  assign full         = full_q;
  assign almost_full  = almost_full_q;
  assign wrusedw      = wrusedw_q;
  assign wr_overflow  = wr_overflow_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign rdusedw      = rdusedw_q;
  assign rd_underflow = rd_underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_asyncfifo_gray.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_asyncfifo_gray
// Purpose  : Scoreboard bench for asyncfifo_gray. Two instances share stimulus:
//            u_reg (registered q, AFULL_TH=6, AEMPTY_TH=2) and u_sa
//            (show-ahead q, default thresholds 4/4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_asyncfifo_gray;

  logic       wrclk = 1'b0;
  logic       rdclk = 1'b0;
  real        rd_half = 5.0;
  logic       wr_aclr = 1'b1;
  logic       rd_aclr = 1'b1;
  logic [7:0] data = '0;
  logic       wrreq = 1'b0;
  logic       rdreq = 1'b0;

  logic       full1, af1, ovf1, empty1, ae1, udf1;
  logic [3:0] wused1, rused1;
  logic [7:0] q1;
  logic       full2, af2, ovf2, empty2, ae2, udf2;
  logic [3:0] wused2, rused2;
  logic [7:0] q2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb [$];

  always #5 wrclk = ~wrclk;
  always #(rd_half) rdclk = ~rdclk;

  asyncfifo_gray #(.WIDTH(8), .AWIDTH(3), .SHOWAHEAD(1'b0), .SYNC_STAGES(2),
                   .AFULL_TH(6), .AEMPTY_TH(2)) u_reg (
    .wrclk(wrclk), .wr_aclr(wr_aclr), .rdclk(rdclk), .rd_aclr(rd_aclr),
    .data(data), .wrreq(wrreq), .full(full1), .almost_full(af1),
    .wrusedw(wused1), .wr_overflow(ovf1), .rdreq(rdreq), .q(q1),
    .empty(empty1), .almost_empty(ae1), .rdusedw(rused1), .rd_underflow(udf1));

  asyncfifo_gray #(.WIDTH(8), .AWIDTH(3), .SHOWAHEAD(1'b1), .SYNC_STAGES(2)) u_sa (
    .wrclk(wrclk), .wr_aclr(wr_aclr), .rdclk(rdclk), .rd_aclr(rd_aclr),
    .data(data), .wrreq(wrreq), .full(full2), .almost_full(af2),
    .wrusedw(wused2), .wr_overflow(ovf2), .rdreq(rdreq), .q(q2),
    .empty(empty2), .almost_empty(ae2), .rdusedw(rused2), .rd_underflow(udf2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One write cycle; the scoreboard only receives words the FIFO must accept.
  task automatic wr1(input logic [7:0] d, input bit expect_accept);
    @(negedge wrclk);
    data  = d;
    wrreq = 1'b1;
    if (expect_accept) sb.push_back(d);
    @(negedge wrclk);
    wrreq = 1'b0;
  endtask

  // One read cycle compared against the scoreboard head.
  task automatic rd1(input string tag);
    logic [7:0] e;
    @(negedge rdclk);
    e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    chk({tag, "_sa"}, 32'(q2), 32'(e));
    rdreq = 1'b1;
    @(negedge rdclk);
    rdreq = 1'b0;
    chk({tag, "_reg"}, 32'(q1), 32'(e));
  endtask

  task automatic rd_idle(input int n);
    for (int i = 0; i < n; i++) @(negedge rdclk);
  endtask

  task automatic wr_idle(input int n);
    for (int i = 0; i < n; i++) @(negedge wrclk);
  endtask

  initial begin
    // ---- reset state
    #12;
    chk("rst_empty", 32'(empty1), 32'd1);
    chk("rst_full", 32'(full1), 32'd0);
    chk("rst_ae", 32'(ae1), 32'd1);
    chk("rst_af", 32'(af1), 32'd0);
    chk("rst_q", 32'(q1), 32'd0);
    @(negedge wrclk);
    wr_aclr = 1'b0;
    rd_aclr = 1'b0;

    // ---- latency: write at edge N, empty falls after read edge N+2
    @(negedge wrclk);
    data = 8'hA5; wrreq = 1'b1; sb.push_back(8'hA5);
    @(posedge wrclk); #1;
    wrreq = 1'b0;
    chk("lat_wrusedw", 32'(wused1), 32'd1);
    chk("lat_empty_n0", 32'(empty1), 32'd1);
    @(posedge rdclk); #1;
    chk("lat_empty_n1", 32'(empty1), 32'd1);
    @(posedge rdclk); #1;
    chk("lat_empty_n2", 32'(empty1), 32'd0);
    chk("lat_rdusedw", 32'(rused1), 32'd1);
    rd1("lat_q");
    rd_idle(1);
    chk("lat_empty_after", 32'(empty1), 32'd1);
    wr_idle(4);
    chk("lat_wrusedw_after", 32'(wused1), 32'd0);

    // ---- fill 0x10..0x17, then one write into a full FIFO
    for (int k = 1; k <= 8; k++) begin
      wr1(8'(8'h0F + k), 1'b1);
      chk("fill_wrusedw", 32'(wused1), 32'(k));
      chk("fill_af6", 32'(af1), 32'(k >= 6));
      chk("fill_af4", 32'(af2), 32'(k >= 4));
      chk("fill_full", 32'(full1), 32'(k == 8));
    end
    chk("fill_ovf_pre", 32'(ovf1), 32'd0);
    wr1(8'hFF, 1'b0);
    chk("fill_ovf", 32'(ovf1), 32'd1);
    chk("fill_wrusedw8", 32'(wused1), 32'd8);
    chk("fill_full8", 32'(full2), 32'd1);
    rd_idle(4);
    chk("fill_rdusedw", 32'(rused1), 32'd8);
    chk("fill_ae", 32'(ae1), 32'd0);

    // ---- drain in order, then underflow
    for (int k = 0; k < 8; k++) begin
      @(negedge rdclk);
      chk("drain_rdusedw", 32'(rused1), 32'(8 - k));
      chk("drain_ae2", 32'(ae1), 32'((8 - k) <= 2));
      chk("drain_ae4", 32'(ae2), 32'((8 - k) <= 4));
      rd1("drain_q");
    end
    chk("drain_empty", 32'(empty1), 32'd1);
    chk("drain_udf_pre", 32'(udf1), 32'd0);
    @(negedge rdclk); rdreq = 1'b1;
    @(negedge rdclk); rdreq = 1'b0;
    chk("drain_udf", 32'(udf1), 32'd1);
    chk("drain_rdusedw0", 32'(rused1), 32'd0);
    wr1(8'h5A, 1'b1);
    rd_idle(4);
    rd1("post_udf_q");
    wr_idle(4);
    chk("drain_full_clear", 32'(full1), 32'd0);

    // ---- reset both domains mid-traffic
    wr1(8'h01, 1'b0);
    wr1(8'h02, 1'b0);
    @(negedge wrclk);
    data = 8'h03; wrreq = 1'b1;
    #2;
    wr_aclr = 1'b1; rd_aclr = 1'b1;
    #1;
    wrreq = 1'b0;
    chk("mid_rst_empty", 32'(empty1), 32'd1);
    chk("mid_rst_full", 32'(full1), 32'd0);
    chk("mid_rst_wrusedw", 32'(wused1), 32'd0);
    chk("mid_rst_rdusedw", 32'(rused1), 32'd0);
    chk("mid_rst_ovf", 32'(ovf1), 32'd0);
    chk("mid_rst_udf", 32'(udf1), 32'd0);
    chk("mid_rst_q", 32'(q1), 32'd0);
    wr_idle(3);
    sb.delete();
    wr_aclr = 1'b0; rd_aclr = 1'b0;
    wr_idle(2);

    // ---- random CDC traffic with wrap, two read clock rates
    rd_half = 3.5;
    fork
      begin : wr_proc
        int nw = 0;
        int cyc = 0;
        logic [7:0] d;
        while (nw < 1000 && cyc < 40000) begin
          @(negedge wrclk);
          cyc++;
          if ($urandom_range(0, 1) == 1 && !full1) begin
            d = 8'($urandom);
            data = d; wrreq = 1'b1;
            sb.push_back(d);
            nw++;
          end else begin
            wrreq = 1'b0;
          end
        end
        @(negedge wrclk);
        wrreq = 1'b0;
        chk("cdc_writes", 32'(nw), 32'd1000);
      end
      begin : rd_proc
        int nr = 0;
        int cyc = 0;
        bit pend = 1'b0;
        logic [7:0] e = '0;
        while (nr < 1000 && cyc < 40000) begin
          @(negedge rdclk);
          cyc++;
          if (pend) begin
            chk("cdc_q_reg", 32'(q1), 32'(e));
            nr++;
            pend = 1'b0;
          end
          if (nr == 500) rd_half = 6.5;
          if (nr < 1000 && $urandom_range(0, 2) != 0 && !empty1 && sb.size() > 0) begin
            e = sb.pop_front();
            chk("cdc_q_sa", 32'(q2), 32'(e));
            rdreq = 1'b1;
            pend = 1'b1;
          end else begin
            rdreq = 1'b0;
          end
        end
        rdreq = 1'b0;
        chk("cdc_reads", 32'(nr), 32'd1000);
      end
    join
    rd_idle(4);
    wr_idle(4);
    chk("cdc_ovf", 32'(ovf1), 32'd0);
    chk("cdc_udf", 32'(udf1), 32'd0);
    chk("cdc_empty", 32'(empty1), 32'd1);
    chk("cdc_wrusedw", 32'(wused1), 32'd0);
    chk("cdc_sb_left", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/asyncfifo_gray.md
# asyncfifo_gray

Dual-clock FIFO with Gray-coded pointer synchronisation. Provides registered-safe full/empty, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags and a selectable show-ahead or registered-read mode. Sits at clock-domain crossings between the packet datapath (wrclk) and core/peripheral logic (rdclk). Replaces the simple binary-pointer FIFO for all new CDC buffering.

## Interface
- WIDTH, 32, data word width
- AWIDTH, 10, address bits; depth = 2^AWIDTH entries, all usable
- SHOWAHEAD, 1, 1: q shows head word while !empty; 0: q registered, updated on accepted read
- SYNC_STAGES, 2, synchroniser flops per crossing (>=2)
- AFULL_TH, 2^AWIDTH-4, almost_full threshold (words)
- AEMPTY_TH, 4, almost_empty threshold (words)

- wrclk  in  1  write clock
- wr_aclr  in  1  write-domain reset, asynchronous, active-high
- rdclk  in  1  read clock
- rd_aclr  in  1  read-domain reset, asynchronous, active-high
- data  in  WIDTH  write data
- wrreq  in  1  write request
- full  out  1  no free entry
- almost_full  out  1  wrusedw >= AFULL_TH
- wrusedw  out  AWIDTH+1  occupancy, write-domain view
- wr_overflow  out  1  sticky: wrreq seen while full
- rdreq  in  1  read request
- q  out  WIDTH  read data
- empty  out  1  no valid entry
- almost_empty  out  1  rdusedw <= AEMPTY_TH
- rdusedw  out  AWIDTH+1  occupancy, read-domain view
- rd_underflow  out  1  sticky: rdreq seen while empty

## Operation
- Pointers AWIDTH+1 bits, binary + Gray copy, both registered; memory addressed by low AWIDTH bits.
- Write accepted iff wrreq & !full: mem[wptr] <= data, wptr++. wrreq & full: no write, wr_overflow <= 1.
- Read accepted iff rdreq & !empty: rptr++. rdreq & empty: no pointer change, rd_underflow <= 1.
- Gray wptr crosses to rdclk, Gray rptr crosses to wrclk, each through SYNC_STAGES flops; only Gray values cross.
- full = (wgray == synced rgray with top two bits inverted). empty = (rgray == synced wgray).
- wrusedw = wbin - gray2bin(synced rgray); rdusedw = gray2bin(synced wgray) - rbin; modulo 2^(AWIDTH+1), range 0..2^AWIDTH.
- Flags pessimistic: full/wrusedw may overstate, empty/rdusedw may understate, never the reverse.
- SHOWAHEAD=1: q = mem[rptr] combinationally; valid only while !empty.
- SHOWAHEAD=0: accepted read loads q <= mem[rptr]; q holds otherwise.
- Memory not cleared by reset.
- Reset values: wr_aclr -> wptr=0, write-side syncs=0, full=0, almost_full=0, wrusedw=0, wr_overflow=0. rd_aclr -> rptr=0, read-side syncs=0, empty=1, almost_empty=1, rdusedw=0, rd_underflow=0, q=0 (SHOWAHEAD=0).
- Flush requires both resets asserted overlapping; single-domain reset mid-operation gives undefined occupancy until the other is reset. Sticky flags clear only by their domain's reset.

## Timing
- Write at wrclk edge N: full/wrusedw/almost_full update immediately after edge N (same domain).
- Same write visible to read side after SYNC_STAGES rdclk edges following edge N: empty falls, rdusedw increments.
- Symmetric for reads: full falls SYNC_STAGES wrclk edges after the read edge.
- SHOWAHEAD=0: q valid one rdclk edge after the accepting edge.
- Simultaneous write and read in unrelated clocks: both accepted if flags allow; occupancy converges after sync latency.
- Pointer wrap at 2^(AWIDTH+1) seamless; no flag glitch.

## Test plan
- Reset: assert both resets mid-traffic -> empty=1, full=0, wrusedw=rdusedw=0, flags=0, q=0 (SHOWAHEAD=0).
- Fill (WIDTH=8, AWIDTH=3): write 0x10..0x17 -> full=1, wrusedw=8, almost_full at 4; 9th write ignored, wr_overflow=1, contents intact.
- Drain: read 8 words -> 0x10..0x17 in order, empty=1; extra rdreq -> rd_underflow=1, rptr unchanged.
- Latency (equal 10 ns clocks, SYNC_STAGES=2): single write at edge N -> empty=0 after rdclk edge N+2; SHOWAHEAD=0 q=written word one edge after rdreq.
- Wrap/CDC: wrclk 10 ns, rdclk 7 ns then 13 ns, 1000 random words with random wrreq/rdreq -> scoreboard exact, no overflow/underflow when requests gated by flags, pointers wrap >60 times.
- Thresholds: AFULL_TH=6, AEMPTY_TH=2 -> almost_full at wrusedw=6, almost_empty cleared at rdusedw=3.
